// File: rtl/store_narrow.sv
// Store narrowing unit: byte/half/word stores into word-only data memory.
// Sub-word stores read the target word, merge the new lane(s) and write it
// back. Word stores are written directly. Misaligned or reserved-size
// requests complete with a fault and touch no memory.
module store_narrow #(
    parameter int ADDR_W     = 32,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_size,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [31:0]       mem_rd_data,
    input  logic              mem_rd_valid,
    output logic              mem_wr_en,
    output logic [31:0]       mem_wr_data,
    output logic              done,
    output logic              misaligned
);

    typedef enum logic [2:0] {
        S_IDLE, S_FAULT, S_READ, S_WAIT, S_WRITE, S_DONE
    } state_t;

    state_t      state;
    logic [1:0]  off_q;    // byte offset within the word
    logic        half_q;   // 1: half store, 0: byte store
    logic [15:0] data_q;   // only the low half of the register can reach memory

    logic        fault_in;
    logic [4:0]  sh;
    logic [31:0] mask;
    logic [31:0] ins;
    logic [31:0] merged;

    // Only IDLE accepts requests.
    assign req_ready = (state == S_IDLE);

    // Alignment check on the live request, used in the accept cycle.
    always_comb begin
        fault_in = 1'b0;
        case (req_size)
            2'b00:   fault_in = 1'b0;
            2'b01:   fault_in = req_addr[0];
            2'b10:   fault_in = |req_addr[1:0];
            default: fault_in = 1'b1;
        endcase
    end

    // Lane placement: shift amount of the stored lane(s) within the word.
    always_comb begin
        sh   = 5'd0;
        mask = 32'h0;
        ins  = 32'h0;
        if (half_q) begin
            sh   = BIG_ENDIAN ? {~off_q[1], 4'b0000} : {off_q[1], 4'b0000};
            mask = 32'h0000_FFFF << sh;
            ins  = {16'h0000, data_q} << sh;
        end else begin
            sh   = BIG_ENDIAN ? {~off_q, 3'b000} : {off_q, 3'b000};
            mask = 32'h0000_00FF << sh;
            ins  = {24'h000000, data_q[7:0]} << sh;
        end
        merged = (mem_rd_data & ~mask) | ins;
    end

    // Control FSM; every output is set on the edge entering its state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            mem_rd_en   <= 1'b0;
            mem_wr_en   <= 1'b0;
            done        <= 1'b0;
            misaligned  <= 1'b0;
            mem_addr    <= '0;
            mem_wr_data <= 32'h0;
            off_q       <= 2'b00;
            half_q      <= 1'b0;
            data_q      <= 16'h0;
        end else begin
            mem_rd_en  <= 1'b0;
            mem_wr_en  <= 1'b0;
            done       <= 1'b0;
            misaligned <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        off_q    <= req_addr[1:0];
                        half_q   <= req_size[0];
                        data_q   <= req_data[15:0];
                        mem_addr <= {req_addr[ADDR_W-1:2], 2'b00};
                        if (fault_in) begin
                            state      <= S_FAULT;
                            done       <= 1'b1;
                            misaligned <= 1'b1;
                        end else if (req_size == 2'b10) begin
                            state       <= S_WRITE;
                            mem_wr_en   <= 1'b1;
                            mem_wr_data <= req_data;
                        end else begin
                            state     <= S_READ;
                            mem_rd_en <= 1'b1;
                        end
                    end
                end
                S_FAULT: state <= S_IDLE;
                S_READ:  state <= S_WAIT;
                S_WAIT: begin
                    if (mem_rd_valid) begin
                        state       <= S_WRITE;
                        mem_wr_en   <= 1'b1;
                        mem_wr_data <= merged;
                    end
                end
                S_WRITE: begin
                    state <= S_DONE;
                    done  <= 1'b1;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_store_narrow.sv
// Directed bench for store_narrow: a big-endian and a little-endian instance
// share stimulus; expected writes go into a queue and are popped on each
// observed write strobe.
module tb_store_narrow;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid_be = 1'b0;
    logic        req_valid_le = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_data = 32'h0;
    logic [31:0] mem_rd_data = 32'h0;
    logic        mem_rd_valid = 1'b0;

    logic        be_ready, be_rd_en, be_wr_en, be_done, be_mis;
    logic [31:0] be_addr, be_wdata;
    logic        le_ready, le_rd_en, le_wr_en, le_done, le_mis;
    logic [31:0] le_addr, le_wdata;

    store_narrow #(.ADDR_W(32), .BIG_ENDIAN(1'b1)) dut_be (
        .clk(clk), .rst(rst), .req_valid(req_valid_be), .req_ready(be_ready),
        .req_size(req_size), .req_addr(req_addr), .req_data(req_data),
        .mem_addr(be_addr), .mem_rd_en(be_rd_en), .mem_rd_data(mem_rd_data),
        .mem_rd_valid(mem_rd_valid), .mem_wr_en(be_wr_en), .mem_wr_data(be_wdata),
        .done(be_done), .misaligned(be_mis)
    );

    store_narrow #(.ADDR_W(32), .BIG_ENDIAN(1'b0)) dut_le (
        .clk(clk), .rst(rst), .req_valid(req_valid_le), .req_ready(le_ready),
        .req_size(req_size), .req_addr(req_addr), .req_data(req_data),
        .mem_addr(le_addr), .mem_rd_en(le_rd_en), .mem_rd_data(mem_rd_data),
        .mem_rd_valid(mem_rd_valid), .mem_wr_en(le_wr_en), .mem_wr_data(le_wdata),
        .done(le_done), .misaligned(le_mis)
    );

    always #5 clk = ~clk;

    // Selected instance view: sel=0 big-endian, sel=1 little-endian.
    logic        sel = 1'b0;
    logic        ready_s, rd_en_s, wr_en_s, done_s, mis_s;
    logic [31:0] addr_s, wdata_s;
    assign ready_s = sel ? le_ready : be_ready;
    assign rd_en_s = sel ? le_rd_en : be_rd_en;
    assign wr_en_s = sel ? le_wr_en : be_wr_en;
    assign done_s  = sel ? le_done  : be_done;
    assign mis_s   = sel ? le_mis   : be_mis;
    assign addr_s  = sel ? le_addr  : be_addr;
    assign wdata_s = sel ? le_wdata : be_wdata;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    logic [31:0] exp_rd_addr = 32'h0;
    logic [63:0] wq[$];   // {word address, write data}

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Write/read strobe monitor with scoreboard pop.
    always @(negedge clk) begin
        if (rd_en_s) begin
            rd_cnt++;
            chk("rd_addr", addr_s, exp_rd_addr);
        end
        if (wr_en_s) begin
            logic [63:0] e;
            wr_cnt++;
            chk("write_expected", 32'(wq.size() != 0), 32'd1);
            if (wq.size() != 0) begin
                e = wq.pop_front();
                chk("wr_addr", addr_s, e[63:32]);
                chk("wr_data", wdata_s, e[31:0]);
            end
        end
    end

    // One store: drive, serve the read with the given latency, check completion.
    task automatic do_store(input logic [1:0] sz, input logic [31:0] addr,
                            input logic [31:0] data, input logic [31:0] rdw,
                            input int lat, input logic exp_fault,
                            input logic [31:0] exp_wd, input int exp_lat);
        int rd0, wr0, acc, rv_at;
        bit seen;
        @(negedge clk);
        chk("ready_pre", 32'(ready_s), 32'd1);
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        exp_rd_addr = {addr[31:2], 2'b00};
        if (!exp_fault) wq.push_back({exp_rd_addr, exp_wd});
        req_size = sz;
        req_addr = addr;
        req_data = data;
        if (sel) req_valid_le = 1'b1; else req_valid_be = 1'b1;
        rv_at = -1;
        seen = 1'b0;
        acc = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (k == 0) begin
                req_valid_be = 1'b0;
                req_valid_le = 1'b0;
                acc = cyc;
                // Captured request must not follow later input changes.
                req_addr = 32'hFFFF_FFFF;
                req_data = 32'h0;
                req_size = 2'b10;
            end
            mem_rd_valid = (k == rv_at);
            mem_rd_data  = (k == rv_at) ? rdw : 32'h0BAD_0BAD;
            if (rd_en_s) rv_at = k + lat;
            if (done_s) seen = 1'b1;
        end
        mem_rd_valid = 1'b0;
        chk("done_seen", 32'(seen), 32'd1);
        if (seen) begin
            chk("done_latency", 32'(cyc - acc + 1), 32'(exp_lat));
            chk("misaligned", 32'(mis_s), 32'(exp_fault));
            chk("rd_count", 32'(rd_cnt - rd0), 32'((!exp_fault && sz != 2'b10) ? 1 : 0));
            chk("wr_count", 32'(wr_cnt - wr0), 32'(exp_fault ? 0 : 1));
            chk("queue_empty", 32'(wq.size()), 32'd0);
        end
    endtask

    initial begin
        int wr0;
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(be_ready), 32'd1);
        chk("rst_rd_en", 32'(be_rd_en), 32'd0);
        chk("rst_wr_en", 32'(be_wr_en), 32'd0);
        chk("rst_done", 32'(be_done), 32'd0);
        chk("rst_mis", 32'(be_mis), 32'd0);
        chk("rst_addr", be_addr, 32'd0);
        chk("rst_wdata", be_wdata, 32'd0);
        chk("rst_ready_le", 32'(le_ready), 32'd1);
        rst = 1'b0;

        // Big-endian instance
        sel = 1'b0;
        do_store(2'b10, 32'h100, 32'hDEADBEEF, 32'h0, 1, 1'b0, 32'hDEADBEEF, 2);
        do_store(2'b00, 32'h102, 32'hFFFFFF5A, 32'h11223344, 1, 1'b0, 32'h11225A44, 4);
        do_store(2'b01, 32'h202, 32'h0000CAFE, 32'hAABBCCDD, 3, 1'b0, 32'hAABBCAFE, 6);
        do_store(2'b01, 32'h301, 32'h00001234, 32'h0, 1, 1'b1, 32'h0, 1);
        do_store(2'b10, 32'h302, 32'h12345678, 32'h0, 1, 1'b1, 32'h0, 1);
        do_store(2'b11, 32'h000, 32'h12345678, 32'h0, 1, 1'b1, 32'h0, 1);
        do_store(2'b00, 32'h500, 32'h000000AB, 32'h00000000, 2, 1'b0, 32'hAB000000, 5);
        do_store(2'b01, 32'h504, 32'h00005555, 32'hFFFFFFFF, 1, 1'b0, 32'h5555FFFF, 4);

        // Reset while waiting for read data: no write, ready right after
        @(negedge clk);
        wr0 = wr_cnt;
        exp_rd_addr = 32'h600;
        req_size = 2'b00;
        req_addr = 32'h601;
        req_data = 32'h11;
        req_valid_be = 1'b1;
        @(negedge clk);
        req_valid_be = 1'b0;
        chk("rst_mid_rd_en", 32'(be_rd_en), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_ready", 32'(be_ready), 32'd1);
        mem_rd_valid = 1'b1;
        mem_rd_data = 32'h55555555;
        @(negedge clk);
        mem_rd_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mid_no_write", 32'(wr_cnt - wr0), 32'd0);
        chk("rst_mid_no_done", 32'(be_done), 32'd0);
        do_store(2'b10, 32'h400, 32'h12345678, 32'h0, 1, 1'b0, 32'h12345678, 2);

        // Little-endian instance
        sel = 1'b1;
        do_store(2'b00, 32'h003, 32'h00000077, 32'h00000000, 1, 1'b0, 32'h77000000, 4);
        do_store(2'b01, 32'h002, 32'hFFFF1234, 32'hAAAAAAAA, 2, 1'b0, 32'h1234AAAA, 5);
        do_store(2'b01, 32'h003, 32'h00001234, 32'h0, 1, 1'b1, 32'h0, 1);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
